instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/loader_pkg.sv | 28 ++
 rtl/instr_loader.sv | 168 ++++++++++++++++
 tb/tb_instr_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: word framing, FSM states
// and the running checksum helpers.
package loader_pkg;

   // Every instruction word travels as five bytes, sized for the widest
   // supported instruction (40 bits), regardless of the configured width.
   localparam int unsigned BYTES_PER_WORD = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Fold one accepted byte into the running XOR checksum.
   function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                              input logic [7:0] data);
      return csum ^ data;
   endfunction

   // The trailing check byte is the one's complement of the XOR of all
   // image bytes, so an all-zero stream is not accepted by a zero trailer.
   function automatic logic [7:0] csum_expected(input logic [7:0] csum);
      return ~csum;
   endfunction

endpackage

// File: rtl/instr_loader.sv
// Instruction loader: assembles a byte stream into instruction words,
// writes them to the instruction memory, verifies a trailing checksum byte
// and keeps the processor held in reset while loading or after a bad image.
module instr_loader
   import loader_pkg::*;
#(
   parameter int INSTRUCTIONS_SIZE = 20,
   parameter int INSTRUCTION_WIDTH = 36
) (
   input  logic                                 pixel_clk_in,
   input  logic                                 rst_in,
   input  logic                                 load_start_in,
   input  logic                                 byte_valid_in,
   input  logic [7:0]                           byte_in,
   output logic                                 imem_we_out,
   output logic [$clog2(INSTRUCTIONS_SIZE)-1:0] imem_addr_out,
   output logic [INSTRUCTION_WIDTH-1:0]         imem_data_out,
   output logic                                 busy_out,
   output logic                                 done_out,
   output logic                                 error_out,
   output logic                                 proc_hold_out
);

   localparam int AW = $clog2(INSTRUCTIONS_SIZE);
   localparam logic [AW-1:0] LAST_ADDR = AW'(INSTRUCTIONS_SIZE - 1);
   localparam logic [2:0]    LAST_BYTE = 3'(BYTES_PER_WORD - 1);

   state_t                         state_r;
   state_t                         state_s;
   logic [2:0]                     byte_cnt_r;
   logic [AW-1:0]                  addr_r;
   logic [INSTRUCTION_WIDTH-1:0]   shreg_r;
   logic [INSTRUCTION_WIDTH-1:0]   shift_s;
   logic [7:0]                     csum_r;
   logic                           we_r;
   logic                           busy_r;
   logic                           done_r;
   logic                           error_r;
   logic                           hold_r;
   logic                           start_s;
   logic                           accept_s;
   logic                           word_done_s;
   logic                           check_s;
   logic                           mismatch_s;

   // Only the low INSTRUCTION_WIDTH bits of the 40-bit framed word ever reach
   // the memory, so the register keeps just those and lets the rest fall off.
   generate
      if (INSTRUCTION_WIDTH > 8) begin : g_wide
         assign shift_s = {shreg_r[INSTRUCTION_WIDTH-9:0], byte_in};
      end else begin : g_narrow
         assign shift_s = byte_in[INSTRUCTION_WIDTH-1:0];
      end
   endgenerate

   // Next-state decode and per-cycle strobes for the datapath.
   always_comb begin
      state_s     = state_r;
      start_s     = 1'b0;
      accept_s    = 1'b0;
      word_done_s = 1'b0;
      check_s     = 1'b0;
      mismatch_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (load_start_in) begin
               start_s = 1'b1;
               state_s = RECV;
            end else begin
               state_s = IDLE;
            end
         end
         RECV: begin
            if (byte_valid_in) begin
               accept_s = 1'b1;
               if (byte_cnt_r == LAST_BYTE) begin
                  word_done_s = 1'b1;
                  if (addr_r == LAST_ADDR) begin
                     state_s = CHECK;
                  end else begin
                     state_s = RECV;
                  end
               end else begin
                  state_s = RECV;
               end
            end else begin
               state_s = RECV;
            end
         end
         CHECK: begin
            if (byte_valid_in) begin
               check_s    = 1'b1;
               mismatch_s = (byte_in != csum_expected(csum_r));
               state_s    = DONE;
            end else begin
               state_s = CHECK;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Word assembly, checksum, address stepping and registered status flags.
   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         byte_cnt_r <= 3'd0;
         addr_r     <= '0;
         shreg_r    <= '0;
         csum_r     <= 8'd0;
         we_r       <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
         hold_r     <= 1'b1;
      end else begin
         we_r   <= word_done_s;
         done_r <= check_s;
         if (start_s) begin
            byte_cnt_r <= 3'd0;
            addr_r     <= '0;
            shreg_r    <= '0;
            csum_r     <= 8'd0;
            busy_r     <= 1'b1;
            hold_r     <= 1'b1;
            error_r    <= 1'b0;
         end else begin
            if (accept_s) begin
               shreg_r    <= shift_s;
               csum_r     <= csum_update(csum_r, byte_in);
               byte_cnt_r <= word_done_s ? 3'd0 : byte_cnt_r + 3'd1;
            end
            // The address moves on only after its write cycle and parks on
            // the last word so it can never run past the memory.
            if (we_r && (addr_r != LAST_ADDR)) begin
               addr_r <= addr_r + AW'(1);
            end
            if (check_s) begin
               busy_r  <= 1'b0;
               error_r <= mismatch_s;
               hold_r  <= mismatch_s;
            end
         end
      end
   end

   assign imem_we_out   = we_r;
   assign imem_addr_out = addr_r;
   assign imem_data_out = shreg_r;
   assign busy_out      = busy_r;
   assign done_out      = done_r;
   assign error_out     = error_r;
   assign proc_hold_out = hold_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader with a two-word image: directed table
// vectors, reset/stray-input sequences and randomized images checked against
// a stream-level reference model.
module tb_instr_loader;

   localparam int N = 2;
   localparam int W = 36;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_start = 1'b0;
   logic          bv = 1'b0;
   logic [7:0]    b = 8'd0;
   logic          imem_we;
   logic [0:0]    imem_addr;
   logic [W-1:0]  imem_data;
   logic          busy, done, err, hold;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int we_cnt = 0;
   int done_cnt = 0;
   int we_last_cyc = 0;
   int we_gap = 0;
   logic [0:0]    log_addr [0:63];
   logic [W-1:0]  log_data [0:63];
   logic          done_busy = 1'b1;
   logic          done_hold = 1'b1;
   logic          done_err  = 1'b1;

   typedef struct {
      logic [87:0] bs;
      bit          gapless;
      int          mid_start;
      int          pre_junk;
      logic [W-1:0] w0;
      logic [W-1:0] w1;
      bit          err;
   } vec_t;

   vec_t vecs [0:3];

   instr_loader #(.INSTRUCTIONS_SIZE(N), .INSTRUCTION_WIDTH(W)) dut (
      .pixel_clk_in  (clk),
      .rst_in        (rst_n),
      .load_start_in (load_start),
      .byte_valid_in (bv),
      .byte_in       (b),
      .imem_we_out   (imem_we),
      .imem_addr_out (imem_addr),
      .imem_data_out (imem_data),
      .busy_out      (busy),
      .done_out      (done),
      .error_out     (err),
      .proc_hold_out (hold)
   );

   always #5 clk = ~clk;

   // Observe writes and completion pulses mid-cycle.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (imem_we) begin
         we_cnt              <= we_cnt + 1;
         we_gap              <= cyc - we_last_cyc;
         we_last_cyc         <= cyc;
         log_addr[we_cnt % 64] <= imem_addr;
         log_data[we_cnt % 64] <= imem_data;
      end
      if (done) begin
         done_cnt  <= done_cnt + 1;
         done_busy <= busy;
         done_hold <= hold;
         done_err  <= err;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      bv = 1'b1;
      b  = v;
      tick();
      bv = 1'b0;
      b  = 8'($urandom);
   endtask

   // Reference: word k is bytes 5k..5k+4 MSB-first, truncated to W bits.
   function automatic logic [W-1:0] model_word(input logic [87:0] bs, input int k);
      logic [39:0] w;
      w = bs[87-40*k -: 40];
      return w[W-1:0];
   endfunction

   // Reference: the good trailer is the complement of the XOR of all 10 image bytes.
   function automatic logic [7:0] model_cks(input logic [87:0] bs);
      logic [7:0] x;
      x = 8'd0;
      for (int i = 0; i < 10; i++) x = x ^ bs[87-8*i -: 8];
      return ~x;
   endfunction

   task automatic run_load(input string name, input logic [87:0] bs, input bit gapless,
                           input int mid_start, input int pre_junk,
                           input logic [W-1:0] w0, input logic [W-1:0] w1, input bit e);
      int we0;
      int d0;
      for (int j = 0; j < pre_junk; j++) send_byte(8'($urandom));
      we0 = we_cnt;
      d0  = done_cnt;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check({name, " start_flags"}, {61'd0, busy, hold, err}, 64'b110);
      for (int i = 0; i < 11; i++) begin
         if (!gapless) repeat ($urandom_range(0, 3)) tick();
         if (i == mid_start) begin
            load_start = 1'b1;
            tick();
            load_start = 1'b0;
         end
         send_byte(bs[87-8*i -: 8]);
      end
      send_byte(8'($urandom));
      for (int k = 0; k < 40 && done_cnt == d0; k++) tick();
      if (done_cnt == d0) check({name, " done_timeout"}, 64'd0, 64'd1);
      repeat (3) tick();
      check({name, " done_pulses"}, 64'(done_cnt - d0), 64'd1);
      check({name, " we_pulses"}, 64'(we_cnt - we0), 64'd2);
      check({name, " word0"}, {27'd0, log_addr[we0 % 64], log_data[we0 % 64]}, {27'd0, 1'b0, w0});
      check({name, " word1"}, {27'd0, log_addr[(we0 + 1) % 64], log_data[(we0 + 1) % 64]}, {27'd0, 1'b1, w1});
      if (gapless) check({name, " we_spacing_ok"}, 64'(we_gap >= 2 && we_gap <= 6), 64'd1);
      check({name, " done_cycle_flags"}, {61'd0, done_busy, done_hold, done_err}, {61'd0, 1'b0, e, e});
      check({name, " held_flags"}, {60'd0, busy, done, err, hold}, {60'd0, 1'b0, 1'b0, e, e});
   endtask

   initial begin
      logic [87:0] rbs;
      bit          bad;
      int          we0;
      repeat (3) @(negedge clk);
      check("rst_we", 64'(imem_we), 64'd0);
      check("rst_addr", 64'(imem_addr), 64'd0);
      check("rst_data", 64'(imem_data), 64'd0);
      check("rst_flags", {60'd0, busy, done, err, hold}, 64'b0001);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();

      vecs[0] = '{88'h0F_FFFFFFFF_0000000001_F1, 1'b0, -1, 0, 36'hFFFFFFFFF, 36'h000000001, 1'b0};
      vecs[1] = '{88'h0F_FFFFFFFF_0000000001_00, 1'b0, -1, 0, 36'hFFFFFFFFF, 36'h000000001, 1'b1};
      vecs[2] = '{88'h0F_FFFFFFFF_0000000001_F1, 1'b1, -1, 0, 36'hFFFFFFFFF, 36'h000000001, 1'b0};
      vecs[3] = '{88'h0F_FFFFFFFF_0000000001_F1, 1'b0,  4, 3, 36'hFFFFFFFFF, 36'h000000001, 1'b0};
      for (int v = 0; v < 4; v++)
         run_load($sformatf("vec%0d", v), vecs[v].bs, vecs[v].gapless, vecs[v].mid_start,
                  vecs[v].pre_junk, vecs[v].w0, vecs[v].w1, vecs[v].err);

      // Reset in the middle of a load: abort with no writes, then reload cleanly.
      we0 = we_cnt;
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      send_byte(8'h0F);
      send_byte(8'hFF);
      send_byte(8'hFF);
      rst_n = 1'b0;
      #1;
      check("midrst_outputs", {25'd0, imem_we, imem_addr, imem_data}, 64'd0);
      check("midrst_flags", {60'd0, busy, done, err, hold}, 64'b0001);
      repeat (2) tick();
      check("midrst_no_write", 64'(we_cnt - we0), 64'd0);
      rst_n = 1'b1;
      tick();
      run_load("after_rst", vecs[0].bs, 1'b0, -1, 0, vecs[0].w0, vecs[0].w1, 1'b0);

      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 10; i++) rbs[87-8*i -: 8] = 8'($urandom);
         bad = 1'($urandom_range(0, 1));
         rbs[7:0] = model_cks(rbs) ^ (bad ? 8'($urandom_range(1, 255)) : 8'd0);
         run_load($sformatf("rnd%0d", r), rbs, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 14)), int'($urandom_range(0, 2)),
                  model_word(rbs, 0), model_word(rbs, 1), bad);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
